radio_enable_sequencer: RTL and testbench

- Controller that sequences the radio enable pair consumed downstream as radioEnableSynced/radioRxEnSynced, ahead of the synchroniser/register stage.
- Enforces power-before-RX on turn-on and RX-before-power on turn-off, with programmable settle delays.
- Owns the isolation handshake: on request from the power controller it drains both enables to 0 in order, then acknowledges.
- Only after that acknowledge may the M1/M3 isolation cells be clamped.

---
 rtl/radio_enable_sequencer_if.sv | 24 ++
 rtl/radio_enable_sequencer.sv | 121 ++++++++++++
 tb/tb_radio_enable_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/radio_enable_sequencer_if.sv
// Request/config/enable bundle between the power controller (master) and the
// radio enable sequencer (slave).
interface radio_enable_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             rx_req;
  logic             iso_req;
  logic [CNT_W-1:0] cfg_on_dly;
  logic [CNT_W-1:0] cfg_off_dly;
  logic             radio_enable;
  logic             radio_rx_en;
  logic             iso_ack;
  logic             busy;

  modport master (
    output rx_req, iso_req, cfg_on_dly, cfg_off_dly,
    input  radio_enable, radio_rx_en, iso_ack, busy
  );

  modport slave (
    input  rx_req, iso_req, cfg_on_dly, cfg_off_dly,
    output radio_enable, radio_rx_en, iso_ack, busy
  );
endinterface

// File: rtl/radio_enable_sequencer.sv
// Sequences radio power and RX enables (power before RX on, RX before power off)
// and drains both before acknowledging an isolation request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | radio fully off, waiting for rx_req or iso_req
// PWR_ON  | power up, settling cfg_on_dly+1 cycles before RX enable
// RX_ON   | power and RX enabled
// RX_OFF  | RX dropped, settling cfg_off_dly+1 cycles before power off
// PWR_OFF | power dropped, settling cfg_off_dly+1 cycles
// ISO     | both enables drained, isolation acknowledged
module radio_enable_sequencer #(
  parameter int CNT_W = 8
) (
  input logic                     ck,
  input logic                     arst,
  radio_enable_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PWR_ON  = 3'd1,
    RX_ON   = 3'd2,
    RX_OFF  = 3'd3,
    PWR_OFF = 3'd4,
    ISO     = 3'd5
  } state_t;

  // {radio_enable, radio_rx_en, iso_ack, busy}
  localparam logic [3:0] O_IDLE    = 4'b0000;
  localparam logic [3:0] O_PWR_ON  = 4'b1001;
  localparam logic [3:0] O_RX_ON   = 4'b1100;
  localparam logic [3:0] O_RX_OFF  = 4'b1001;
  localparam logic [3:0] O_PWR_OFF = 4'b0001;
  localparam logic [3:0] O_ISO     = 4'b0010;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       outs;
  logic             done;

  assign done = (cnt == '0);

  // Outputs are registered alongside the state, so they are a pure function of
  // the state register with no input-to-output path.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
      outs  <= O_IDLE;
    end else begin
      if (!done) cnt <= cnt - CNT_ONE;
      case (state)
        IDLE: begin
          if (bus.iso_req) begin
            state <= ISO;
            outs  <= O_ISO;
          end else if (bus.rx_req) begin
            state <= PWR_ON;
            outs  <= O_PWR_ON;
            cnt   <= bus.cfg_on_dly;
          end
        end
        PWR_ON: begin
          if (bus.iso_req || !bus.rx_req) begin
            state <= PWR_OFF;
            outs  <= O_PWR_OFF;
            cnt   <= bus.cfg_off_dly;
          end else if (done) begin
            state <= RX_ON;
            outs  <= O_RX_ON;
          end
        end
        RX_ON: begin
          if (bus.iso_req || !bus.rx_req) begin
            state <= RX_OFF;
            outs  <= O_RX_OFF;
            cnt   <= bus.cfg_off_dly;
          end
        end
        RX_OFF: begin
          if (done) begin
            state <= PWR_OFF;
            outs  <= O_PWR_OFF;
            cnt   <= bus.cfg_off_dly;
          end
        end
        PWR_OFF: begin
          // A dropped iso_req never aborts the drain; it only picks the exit.
          if (done) begin
            if (bus.iso_req) begin
              state <= ISO;
              outs  <= O_ISO;
            end else begin
              state <= IDLE;
              outs  <= O_IDLE;
            end
          end
        end
        ISO: begin
          if (!bus.iso_req) begin
            state <= IDLE;
            outs  <= O_IDLE;
          end
        end
        default: begin
          state <= IDLE;
          outs  <= O_IDLE;
        end
      endcase
    end
  end

  assign bus.radio_enable = outs[3];
  assign bus.radio_rx_en  = outs[2];
  assign bus.iso_ack      = outs[1];
  assign bus.busy         = outs[0];

endmodule

// File: tb/tb_radio_enable_sequencer.sv
// Directed bench: drivers push expected output changes (edge, value) into a
// queue; a monitor pops and compares whenever the output vector changes.
module tb_radio_enable_sequencer;
  localparam int CNT_W = 8;

  logic ck   = 1'b0;
  logic arst = 1'b0;

  radio_enable_sequencer_if #(.CNT_W(CNT_W)) bus ();

  radio_enable_sequencer #(.CNT_W(CNT_W)) dut (
    .ck   (ck),
    .arst (arst),
    .bus  (bus)
  );

  always #5 ck = ~ck;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_mon;
  exp_t       e_end;
  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_err  = 0;
  bit         mon_en = 1'b1;
  logic [3:0] prev   = 4'b0000;
  logic [3:0] outs;

  assign outs = {bus.radio_enable, bus.radio_rx_en, bus.iso_ack, bus.busy};

  initial forever begin
    @(posedge ck);
    cyc = cyc + 1;
  end

  // Monitor: invariants every cycle, scoreboard pop on every output change.
  initial forever begin
    @(negedge ck);
    n_cmp++;
    assert (!(bus.radio_rx_en && !bus.radio_enable))
    else begin
      n_err++;
      $display("FAIL inv_rx_needs_pwr cyc=%0d outs=%b required rx_en->enable", cyc, outs);
    end
    n_cmp++;
    assert (!(bus.iso_ack && (bus.radio_enable || bus.radio_rx_en)))
    else begin
      n_err++;
      $display("FAIL inv_ack_drained cyc=%0d outs=%b required ack->enables 0", cyc, outs);
    end
    if (mon_en && (outs !== prev)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%b prev=%b required no change", cyc, outs, prev);
      end else begin
        e_mon = exp_q.pop_front();
        if (e_mon.cyc != cyc || e_mon.v !== outs) begin
          n_err++;
          $display("FAIL out_event got cyc=%0d outs=%b required cyc=%0d outs=%b",
                   cyc, outs, e_mon.cyc, e_mon.v);
        end
      end
    end
    prev = outs;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int e);
    while (cyc < e) @(negedge ck);
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t x;
    x.cyc = c;
    x.v   = v;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, act, req);
    end
  endtask

  int b;

  initial begin
    bus.rx_req      = 1'b0;
    bus.iso_req     = 1'b0;
    bus.cfg_on_dly  = 8'd3;
    bus.cfg_off_dly = 8'd2;
    #1 arst = 1'b1;
    #1 chk("reset_outs", outs, 4'b0000);
    #20 arst = 1'b0;
    @(negedge ck);
    chk("post_reset_idle", outs, 4'b0000);

    // Turn-on/off, with a mid-count config change that must be ignored
    b = cyc + 2;
    wait_cyc(b - 1); bus.rx_req = 1'b1; push(b, 4'b1001); push(b + 4, 4'b1100);
    wait_cyc(b + 1); bus.cfg_on_dly = 8'd9;
    wait_cyc(b + 9); bus.rx_req = 1'b0;
    push(b + 10, 4'b1001); push(b + 13, 4'b0001); push(b + 16, 4'b0000);
    wait_cyc(b + 18); bus.cfg_on_dly = 8'd3; bus.cfg_off_dly = 8'd1;

    // Isolation drain from RX_ON, rx_req toggled inside ISO
    b = cyc + 2;
    wait_cyc(b - 1); bus.rx_req = 1'b1; push(b, 4'b1001); push(b + 4, 4'b1100);
    wait_cyc(b + 9); bus.iso_req = 1'b1;
    push(b + 10, 4'b1001); push(b + 12, 4'b0001); push(b + 14, 4'b0010);
    wait_cyc(b + 15); bus.rx_req = 1'b0;
    wait_cyc(b + 17); bus.rx_req = 1'b1;
    wait_cyc(b + 18); bus.rx_req = 1'b0;
    wait_cyc(b + 19); bus.iso_req = 1'b0; push(b + 20, 4'b0000);
    wait_cyc(b + 22); bus.cfg_on_dly = 8'd5; bus.cfg_off_dly = 8'd2;

    // Abort during PWR_ON; off delay changed after PWR_OFF entry is ignored
    b = cyc + 2;
    wait_cyc(b - 1); bus.rx_req = 1'b1; push(b, 4'b1001);
    wait_cyc(b + 1); bus.rx_req = 1'b0; push(b + 2, 4'b0001); push(b + 5, 4'b0000);
    wait_cyc(b + 2); bus.cfg_off_dly = 8'd7;
    wait_cyc(b + 7); bus.cfg_on_dly = 8'd0; bus.cfg_off_dly = 8'd0;

    // Zero delays: one-cycle pulse, then held request
    b = cyc + 2;
    wait_cyc(b - 1); bus.rx_req = 1'b1;
    push(b, 4'b1001); push(b + 1, 4'b0001); push(b + 2, 4'b0000);
    wait_cyc(b); bus.rx_req = 1'b0;
    wait_cyc(b + 4); bus.rx_req = 1'b1; push(b + 5, 4'b1001); push(b + 6, 4'b1100);
    wait_cyc(b + 9); bus.rx_req = 1'b0;
    push(b + 10, 4'b1001); push(b + 11, 4'b0001); push(b + 12, 4'b0000);
    wait_cyc(b + 14);

    // iso_req beats rx_req in IDLE; rx_req ignored in ISO
    b = cyc + 2;
    wait_cyc(b - 1); bus.iso_req = 1'b1; bus.rx_req = 1'b1; push(b, 4'b0010);
    wait_cyc(b + 2); bus.rx_req = 1'b0;
    wait_cyc(b + 4); bus.rx_req = 1'b1;
    wait_cyc(b + 6); bus.rx_req = 1'b0;
    wait_cyc(b + 9); bus.iso_req = 1'b0; push(b + 10, 4'b0000);
    wait_cyc(b + 12); bus.cfg_on_dly = 8'd1; bus.cfg_off_dly = 8'd2;

    // iso_req dropped during RX_OFF: drain completes, exits to IDLE
    b = cyc + 2;
    wait_cyc(b - 1); bus.rx_req = 1'b1; push(b, 4'b1001); push(b + 2, 4'b1100);
    wait_cyc(b + 4); bus.iso_req = 1'b1;
    push(b + 5, 4'b1001); push(b + 8, 4'b0001); push(b + 11, 4'b0000);
    wait_cyc(b + 6); bus.iso_req = 1'b0; bus.rx_req = 1'b0;
    wait_cyc(b + 13); bus.cfg_on_dly = 8'd3;

    // Asynchronous reset in RX_ON
    b = cyc + 2;
    wait_cyc(b - 1); bus.rx_req = 1'b1; push(b, 4'b1001); push(b + 4, 4'b1100);
    wait_cyc(b + 6);
    chk("rx_on_before_reset", outs, 4'b1100);
    mon_en = 1'b0;
    #2 arst = 1'b1;
    #1 chk("async_reset_drop", outs, 4'b0000);
    bus.rx_req = 1'b0;
    #1 arst = 1'b0;
    @(negedge ck);
    chk("idle_after_reset", outs, 4'b0000);
    #1 mon_en = 1'b1;
    wait_cyc(cyc + 3);
    chk("idle_settled", outs, 4'b0000);

    while (exp_q.size() > 0) begin
      e_end = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_event got none required cyc=%0d outs=%b", e_end.cyc, e_end.v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
